// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter_ctrl timer.
// State encoding and run-mode values.
package counter_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/mod_counter_core.sv
// Modulo up-counter datapath: counts 0..lim, clears on clr.
// wrap flags an enabled step taken from the terminal value.
module mod_counter_core #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    input  logic [N-1:0] lim,
    output logic [N-1:0] q,
    output logic         wrap
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    assign wrap = en && (q_q == lim);
    assign q    = q_q;

    // Next count: explicit compare-and-clear, never relies on overflow.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            if (q_q == lim) begin
                q_d = '0;
            end else begin
                q_d = q_q + N'(1);
            end
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// Programmable timer controller around mod_counter_core.
// Start/stop FSM, prescaler and shadowed configuration.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int N = 8,
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic         mode,
    input  logic [N-1:0] limit,
    input  logic [P-1:0] prescale,
    output logic         busy,
    output logic [N-1:0] q,
    output logic         tick,
    output logic         done
);

    state_t       state_q, state_d;
    logic [P-1:0] pc_q, pc_d;
    logic [N-1:0] lim_q, lim_d;
    logic [P-1:0] psc_q, psc_d;
    logic         mode_q, mode_d;
    logic         tick_q, tick_d;
    logic         done_q, done_d;

    logic load;
    logic adv;
    logic wrap;

    // Accepted start (stop wins) and prescaled advance strobes.
    assign load = (state_q == IDLE) && start && !stop;
    assign adv  = (state_q == RUN) && !stop && (pc_q == psc_q);

    mod_counter_core #(
        .N(N)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .clr  (load),
        .en   (adv),
        .lim  (lim_q),
        .q    (q),
        .wrap (wrap)
    );

    assign busy = (state_q == RUN);
    assign tick = tick_q;
    assign done = done_q;

    // Next-state, prescaler, shadow latch and event pulses.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        lim_d   = lim_q;
        psc_d   = psc_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    lim_d   = limit;
                    psc_d   = prescale;
                    mode_d  = mode;
                    pc_d    = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    pc_d    = '0;
                    state_d = IDLE;
                end else if (pc_q != psc_q) begin
                    pc_d = pc_q + P'(1);
                end else begin
                    pc_d = '0;
                    if (wrap) begin
                        tick_d = 1'b1;
                        if (mode_q == MODE_ONESHOT) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, prescaler, configuration and pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= '0;
            lim_q   <= '0;
            psc_q   <= '0;
            mode_q  <= MODE_ONESHOT;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lim_q   <= lim_d;
            psc_q   <= psc_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl.
// Stimulus pushes per-edge expectations; monitor pops and compares.
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] limit = 8'd0;
    logic [3:0] prescale = 4'd0;
    logic       busy;
    logic [7:0] q;
    logic       tick;
    logic       done;

    typedef struct {
        logic [7:0] q;
        logic       busy;
        logic       tick;
        logic       done;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   seq = 0;

    counter_ctrl #(.N(8), .P(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .mode    (mode),
        .limit   (limit),
        .prescale(prescale),
        .busy    (busy),
        .q       (q),
        .tick    (tick),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Drive one edge worth of commands and queue the expected outputs after it.
    task automatic go(input logic st, input logic sp, input logic rs,
                      input logic [7:0] eq, input logic eb,
                      input logic et, input logic ed);
        exp_t e;
        @(negedge clk);
        start = st;
        stop  = sp;
        reset = rs;
        e.q = eq; e.busy = eb; e.tick = et; e.done = ed; e.id = seq;
        seq++;
        sb.push_back(e);
    endtask

    task automatic cfg(input logic md, input logic [7:0] lm,
                       input logic [3:0] ps);
        mode = md; limit = lm; prescale = ps;
    endtask

    // Monitor: sample just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                total++;
                if (q !== e.q || busy !== e.busy ||
                    tick !== e.tick || done !== e.done) begin
                    bad++;
                    $display("FAIL step%0d: got q=%0d busy=%b tick=%b done=%b want q=%0d busy=%b tick=%b done=%b",
                             e.id, q, busy, tick, done,
                             e.q, e.busy, e.tick, e.done);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        // Reset state.
        go(0, 0, 1, 0, 0, 0, 0);
        go(0, 0, 1, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0, 0);

        // Periodic, limit 7, prescale 0.
        cfg(1, 8'd7, 4'd0);
        go(1, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 7; i++) go(0, 0, 0, 8'(i), 1, 0, 0);
        go(0, 0, 0, 0, 1, 1, 0);
        // Second period: start ignored, config changes ignored.
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) begin
                cfg(0, 8'd2, 4'd5);
                go(1, 0, 0, 8'(i), 1, 0, 0);
            end else begin
                go(0, 0, 0, 8'(i), 1, 0, 0);
            end
        end
        go(0, 0, 0, 0, 1, 1, 0);
        // Stop when q shows 5.
        for (int i = 1; i <= 5; i++) go(0, 0, 0, 8'(i), 1, 0, 0);
        go(0, 1, 0, 5, 0, 0, 0);
        go(0, 0, 0, 5, 0, 0, 0);
        // start+stop in IDLE: stop wins.
        go(1, 1, 0, 5, 0, 0, 0);
        go(0, 0, 0, 5, 0, 0, 0);

        // One-shot, limit 3, prescale 2.
        cfg(0, 8'd3, 4'd2);
        go(1, 0, 0, 0, 1, 0, 0);
        go(0, 0, 0, 0, 1, 0, 0);
        go(0, 0, 0, 0, 1, 0, 0);
        go(0, 0, 0, 1, 1, 0, 0);
        go(0, 0, 0, 1, 1, 0, 0);
        go(0, 0, 0, 1, 1, 0, 0);
        go(0, 0, 0, 2, 1, 0, 0);
        go(0, 0, 0, 2, 1, 0, 0);
        go(0, 0, 0, 2, 1, 0, 0);
        go(0, 0, 0, 3, 1, 0, 0);
        go(0, 0, 0, 3, 1, 0, 0);
        go(0, 0, 0, 3, 1, 0, 0);
        go(0, 0, 0, 0, 0, 1, 1);
        go(0, 0, 0, 0, 0, 0, 0);

        // Stop coincident with terminal advance.
        cfg(1, 8'd2, 4'd0);
        go(1, 0, 0, 0, 1, 0, 0);
        go(0, 0, 0, 1, 1, 0, 0);
        go(0, 0, 0, 2, 1, 0, 0);
        go(0, 1, 0, 2, 0, 0, 0);
        go(0, 0, 0, 2, 0, 0, 0);

        // limit 0, periodic: tick every cycle.
        cfg(1, 8'd0, 4'd0);
        go(1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) go(0, 0, 0, 0, 1, 1, 0);
        go(0, 1, 0, 0, 0, 0, 0);

        // limit 0, one-shot: tick+done on first advance.
        cfg(0, 8'd0, 4'd0);
        go(1, 0, 0, 0, 1, 0, 0);
        go(0, 0, 0, 0, 0, 1, 1);
        go(0, 0, 0, 0, 0, 0, 0);

        // Full 8-bit count.
        cfg(1, 8'd255, 4'd0);
        go(1, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 255; i++) go(0, 0, 0, 8'(i), 1, 0, 0);
        go(0, 0, 0, 0, 1, 1, 0);
        go(0, 0, 0, 1, 1, 0, 0);
        go(0, 1, 0, 1, 0, 0, 0);

        // Reset mid-run at q=4, start held during reset.
        cfg(1, 8'd7, 4'd0);
        go(1, 0, 0, 0, 1, 0, 0);
        for (int i = 1; i <= 4; i++) go(0, 0, 0, 8'(i), 1, 0, 0);
        go(1, 0, 1, 0, 0, 0, 0);
        go(1, 0, 1, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0, 0);
        go(0, 0, 0, 0, 0, 0, 0);

        n = 0;
        while (sb.size() > 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
Name: counter_ctrl

Overview:
- Sequencing controller for the team's mod-N up-counter datapath: a programmable timer built around a modulo counter.
- Accepts start/stop commands and latches its configuration: limit, prescale and mode (one-shot or periodic).
- Gates counter advance through a prescaler and reports terminal-count events.
- Sits between a register/control interface and any logic that needs periodic ticks or a single timed interval.

Parameters:
- N, 8, counter width in bits; `q` and `limit` are N bits.
- P, 4, prescaler width in bits; `prescale` is P bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  command pulse; starts a run when idle.
- stop  input  1  command pulse; aborts a run.
- mode  input  1  0 = one-shot, 1 = periodic; sampled only with an accepted start.
- limit  input  N  terminal value; count sequence is 0..limit, i.e. modulo limit+1; sampled with start.
- prescale  input  P  counter advances once every prescale+1 clocks while running; sampled with start.
- busy  output  1  high while in RUN.
- q  output  N  current count value.
- tick  output  1  one-cycle pulse on each terminal wrap (q goes limit -> 0).
- done  output  1  one-cycle pulse when a one-shot run completes.

Behaviour:
- Reset (reset=1 at an edge):
  - state=IDLE; q=0, busy=0, tick=0, done=0.
  - Prescale counter pc=0; shadow registers lim_r=0, psc_r=0, mode_r=0.
  - Reset overrides every other input, including mid-run; no tick/done is generated on that edge.
- States: IDLE, RUN. Enum lives in the package.
- IDLE:
  - start=1 && stop=0 at edge k: latch limit->lim_r, prescale->psc_r, mode->mode_r; set q=0, pc=0, state=RUN. busy=1 is visible after edge k.
  - start=1 && stop=1 together: stop wins; remain IDLE, nothing latched.
  - Otherwise q holds its last value.
- RUN, evaluated at each edge:
  - stop=1: state=IDLE, busy=0, q frozen at its current value, pc=0, no tick/done. Stop beats a coincident terminal event.
  - Else if pc != psc_r: pc=pc+1, q holds.
  - Else (advance): pc=0.
    - If q != lim_r: q=q+1.
    - If q == lim_r: q=0 and tick=1 for that cycle.
      - mode_r=1: stay in RUN.
      - mode_r=0: done=1 in the same cycle as tick, state=IDLE, busy=0.
  - start during RUN is ignored: no restart, no re-latch.
- Latency:
  - prescale=0: q=1 after edge k+1, where k is the start edge.
  - In general: first advance at edge k+psc_r+1; each later advance every psc_r+1 clocks.
- Arithmetic:
  - q and pc are unsigned; wrap is explicit compare-and-clear, never natural overflow.
  - limit=2^N-1 gives a full binary count; a natural 2^N overflow is therefore never relied on.
- Boundary cases:
  - limit=0: q stays 0; tick fires on every advance. One-shot: tick+done on the first advance.
  - prescale=0: advance every clock.
  - Changing limit, prescale or mode during RUN has no effect until the next accepted start.
- Output timing: tick and done are registered one-cycle pulses, low at all other times. busy equals (state==RUN), registered.

Decomposition:
- Package counter_ctrl_pkg:
  - state_t enum {IDLE, RUN}.
  - Mode constants MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1.
- Sub-module mod_counter_core (param N):
  - Inputs: clk, reset, clr, en, lim.
  - Outputs: q, wrap. wrap is combinational, = en && q==lim.
  - Instantiated once. The FSM, prescaler and shadow registers remain in counter_ctrl.

Test Plan:
- Reset then periodic: N=8, limit=7, prescale=0, mode=1, start at edge k -> q=1..7 on edges k+1..k+7, q=0 with tick=1 at k+8, repeats; busy stays 1; done never asserts.
- One-shot with prescale: limit=3, prescale=2, mode=0 -> q advances every 3 clocks (1,2,3,0); tick=1 and done=1 in the same cycle at edge k+12; busy=0 afterwards; q=0.
- Stop mid-run: periodic limit=7, stop asserted when q=5 -> busy=0 next cycle, q holds 5, no tick; a later start resets q to 0.
- Simultaneous events:
  - stop coincident with a terminal advance (q=limit) -> IDLE, q=limit, tick=0.
  - start+stop in IDLE -> stays IDLE.
  - start in RUN -> ignored, count continues.
- Boundaries: limit=0, prescale=0, periodic -> q=0 and tick=1 every cycle. limit=255 -> full count 0..255 then wrap with tick. Changing limit mid-run -> no effect.
- Reset mid-run: reset at q=4 -> next cycle q=0, busy=0, tick=0, done=0; inputs ignored while reset=1.
